// File: rtl/calc_result_bcd.sv
`default_nettype none
// ============================================================================
// Module  : calc_result_bcd
// Brief   : Signed calculator result -> sign + BCD digits, double dabble one bit
//           per clock. Option macro LEADING_ZERO_BLANK_EN blanks leading zeros (4'hF).
// Rev     : 1.0
// ============================================================================
module calc_result_bcd #(
  parameter int IN_W   = 9,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_neg,
  output logic [4*DIGITS-1:0] out_bcd
);

  localparam int              C_CNT_W = $clog2(IN_W + 1);
  localparam int              C_BCD_W = 4 * DIGITS;
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_neg;
  logic [IN_W-1:0]      r_mag;
  logic [C_BCD_W-1:0]   r_bcd;
  logic [C_CNT_W-1:0]   r_cnt;

  logic                 w_last;
  logic [IN_W-1:0]      w_mag_in;
  logic [C_BCD_W-1:0]   w_adj;
  logic [C_BCD_W-1:0]   w_bcd_shift;
  logic [C_BCD_W-1:0]   w_bcd_final;

  assign w_last   = (r_cnt == C_LAST);
  // Two's complement negate; the most negative input maps onto its own unsigned magnitude.
  assign w_mag_in = in_data[IN_W-1] ? ((~in_data) + IN_W'(1)) : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = CONV;
      end
      CONV: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  assign w_bcd_shift = {w_adj[C_BCD_W-2:0], r_mag[IN_W-1]};

`ifdef LEADING_ZERO_BLANK_EN
  logic w_lead;
  // Blank from the most significant digit down until the first non-zero; digit 0 always shown.
  always_comb begin
    w_bcd_final = w_bcd_shift;
    w_lead      = 1'b1;
    for (int d = DIGITS - 1; d > 0; d--) begin
      if (w_lead && (w_bcd_shift[4*d +: 4] == 4'd0)) w_bcd_final[4*d +: 4] = 4'hF;
      else                                            w_lead = 1'b0;
    end
  end
`else
  always_comb begin
    w_bcd_final = w_bcd_shift;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg <= 1'b0;
      r_mag <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_neg <= in_data[IN_W-1];
            r_mag <= w_mag_in;
            r_bcd <= '0;
            r_cnt <= '0;
          end
        end
        CONV: begin
          r_mag <= {r_mag[IN_W-2:0], 1'b0};
          r_bcd <= w_last ? w_bcd_final : w_bcd_shift;
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_neg = r_neg;
  assign out_bcd = r_bcd;

endmodule
`default_nettype wire
